rggen_avalon_bridge: RTL

- Avalon-MM host-side bridge: accepts requests on a generic rggen bus (valid/ready, access, address, strobe, data) and issues the matching Avalon-MM read or write to a downstream Avalon agent.
- Completes when the agent drops waitrequest, then returns agent response and readdata upstream.
- Sits between a CPU/interconnect-side rggen bus host and any Avalon-MM agent, including rggen register blocks.

---
 rtl/rggen_avalon_bridge.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rggen_avalon_bridge.sv
// rggen bus to Avalon-MM host bridge: one outstanding transfer, waitrequest-paced.
// Optional watchdog abort when RGGEN_AVALON_BRIDGE_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_valid; captures the request into the command regs
// BUSY    | Avalon command driven, waiting for waitrequest low (or watchdog)
// RESPOND | o_ready pulse with the captured status/readdata

module rggen_avalon_bridge #(
    parameter int                   ADDRESS_WIDTH   = 8,
    parameter int                   BUS_WIDTH       = 32,
    parameter int                   TIMEOUT_CYCLES  = 256,
    parameter logic [BUS_WIDTH-1:0] ERROR_READ_DATA = '0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [1:0]               i_access,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [BUS_WIDTH-1:0]     i_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_strobe,
    output logic                     o_ready,
    output logic [1:0]               o_status,
    output logic [BUS_WIDTH-1:0]     o_read_data,
    output logic                     o_read,
    output logic                     o_write,
    output logic [ADDRESS_WIDTH-1:0] o_address,
    output logic [BUS_WIDTH/8-1:0]   o_byteenable,
    output logic [BUS_WIDTH-1:0]     o_writedata,
    input  logic                     i_waitrequest,
    input  logic [1:0]               i_response,
    input  logic [BUS_WIDTH-1:0]     i_readdata
);

    // rggen_access encoding for a read; every other code is treated as a write
    localparam logic [1:0] RGGEN_READ  = 2'b10;
    localparam logic [1:0] SLAVE_ERROR = 2'b10;

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("rggen_avalon_bridge: TIMEOUT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } state_e;

    state_e                     state_q, state_d;
    logic                       read_q, read_d;
    logic                       write_q, write_d;
    logic                       ready_q, ready_d;
    logic [1:0]                 status_q, status_d;
    logic [BUS_WIDTH-1:0]       read_data_q, read_data_d;
    logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
    logic [BUS_WIDTH/8-1:0]     byteenable_q, byteenable_d;
    logic [BUS_WIDTH-1:0]       writedata_q, writedata_d;

`ifdef RGGEN_AVALON_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        read_d       = read_q;
        write_d      = write_q;
        ready_d      = 1'b0;
        status_d     = status_q;
        read_data_d  = read_data_q;
        address_d    = address_q;
        byteenable_d = byteenable_q;
        writedata_d  = writedata_q;
`ifdef RGGEN_AVALON_BRIDGE_TIMEOUT_EN
        timeout_cnt_d = timeout_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    address_d    = i_address;
                    byteenable_d = i_strobe;
                    writedata_d  = i_write_data;
                    read_d       = (i_access == RGGEN_READ);
                    write_d      = (i_access != RGGEN_READ);
                    state_d      = BUSY;
`ifdef RGGEN_AVALON_BRIDGE_TIMEOUT_EN
                    timeout_cnt_d = '0;
`endif
                end
            end
            BUSY: begin
                if (!i_waitrequest) begin
                    status_d    = i_response;
                    read_data_d = read_q ? i_readdata : '0;
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = RESPOND;
                end
`ifdef RGGEN_AVALON_BRIDGE_TIMEOUT_EN
                else begin
                    timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
                    // this waiting cycle is the one that reaches the limit
                    if (timeout_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        status_d    = SLAVE_ERROR;
                        read_data_d = ERROR_READ_DATA;
                        read_d      = 1'b0;
                        write_d     = 1'b0;
                        ready_d     = 1'b1;
                        state_d     = RESPOND;
                    end
                end
`endif
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            ready_q      <= 1'b0;
            status_q     <= 2'b00;
            read_data_q  <= '0;
            address_q    <= '0;
            byteenable_q <= '0;
            writedata_q  <= '0;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            write_q      <= write_d;
            ready_q      <= ready_d;
            status_q     <= status_d;
            read_data_q  <= read_data_d;
            address_q    <= address_d;
            byteenable_q <= byteenable_d;
            writedata_q  <= writedata_d;
        end
    end

`ifdef RGGEN_AVALON_BRIDGE_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timeout_cnt_q <= '0;
        end else begin
            timeout_cnt_q <= timeout_cnt_d;
        end
    end
`else
    // ERROR_READ_DATA only matters to the watchdog abort path
    logic [BUS_WIDTH-1:0] unused_error_read_data;
    assign unused_error_read_data = ERROR_READ_DATA;
`endif

    assign o_ready      = ready_q;
    assign o_status     = status_q;
    assign o_read_data  = read_data_q;
    assign o_read       = read_q;
    assign o_write      = write_q;
    assign o_address    = address_q;
    assign o_byteenable = byteenable_q;
    assign o_writedata  = writedata_q;

endmodule
